fir_uart_sched: RTL and testbench

Single controller that sequences the UART-to-FIR sample path and the FIR-to-UART result path. It replaces the separate receive and transmit control units and the byte-select glue registers around them. It sits between the UART receiver/transmitter and the FIR core at the board top. It pairs received bytes into 16-bit samples and strobes them into the FIR. It buffers FIR results in a small FIFO and serialises each result as two UART bytes, low byte first.

---
 rtl/fir_uart_pkg.sv | 25 ++
 rtl/fir_uart_sched_sample_fifo.sv | 63 ++++++
 rtl/fir_uart_sched.sv | 196 +++++++++++++++++++
 tb/tb_fir_uart_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_uart_pkg.sv
// Shared definitions for the UART <-> FIR sequencing controller.
// Contents:
//   BYTE_W          - UART byte width
//   DEFAULT_OUT_LSB - default LSB of the 16-bit FIR result slice sent over UART
//   rx_state_t      - receive pairing FSM states
//   tx_state_t      - result serialiser FSM states
package fir_uart_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEFAULT_OUT_LSB = 8;

  typedef enum logic {
    RX_LO = 1'b0,
    RX_HI = 1'b1
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    LO_START = 3'd1,
    LO_WAIT  = 3'd2,
    HI_START = 3'd3,
    HI_WAIT  = 3'd4
  } tx_state_t;

endpackage

// File: rtl/fir_uart_sched_sample_fifo.sv
// sample_fifo: small synchronous FIFO holding FIR result words awaiting
// transmission. Read data is presented combinationally from the head entry.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (flushes the FIFO)
//   push, din     - write request and data; accepted when not full, or when
//                   full but a pop happens in the same cycle
//   pop, dout     - read request (ignored when empty) and head data
//   full, empty   - occupancy flags
//   level         - current number of stored words
module sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign dout  = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_uart_sched.sv
// fir_uart_sched: sequences the UART -> FIR sample path and the FIR -> UART
// result path. Received bytes are paired (low first) into 16-bit samples and
// strobed into the FIR; FIR results are buffered and sent as two bytes, low
// byte first. Both paths run independently.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   rx_ready       - one-cycle strobe, rx_data valid
//   rx_data        - received byte
//   fir_in_valid   - one-cycle sample strobe to the FIR
//   fir_in         - registered sample
//   fir_out_valid  - one-cycle FIR result strobe
//   fir_out        - FIR result (slice [OUT_LSB+15:OUT_LSB] is transmitted)
//   tx_busy        - transmitter busy
//   tx_start       - one-cycle transmit request
//   tx_data        - byte to transmit, stable from request until done
//   sample_led     - copy of fir_in
//   overflow       - sticky: a result was dropped on a full FIFO
//   fifo_level     - FIFO occupancy
//   rx_state       - receive FSM state (debug)
//   tx_state       - transmit FSM state (debug)
//
// Handshake semantics: rx_ready, fir_in_valid and fir_out_valid are single-
// cycle strobes with no back-pressure; data is valid only in the strobe
// cycle. On the UART side tx_start is a single-cycle request raised only while
// tx_busy is low; the transmitter accepts it unconditionally, then the byte is
// considered done once tx_busy has been seen high and has dropped again.
module fir_uart_sched
  import fir_uart_pkg::*;
#(
  parameter int DIN_W      = 16,
  parameter int FIR_OUT_W  = 38,
  parameter int OUT_LSB    = DEFAULT_OUT_LSB,
  parameter int FIFO_DEPTH = 4,
  parameter int RX_TIMEOUT = 20000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_ready,
  input  logic [BYTE_W-1:0]             rx_data,
  output logic                          fir_in_valid,
  output logic [DIN_W-1:0]              fir_in,
  input  logic                          fir_out_valid,
  input  logic [FIR_OUT_W-1:0]          fir_out,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [BYTE_W-1:0]             tx_data,
  output logic [DIN_W-1:0]              sample_led,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output rx_state_t                     rx_state,
  output tx_state_t                     tx_state
);

  localparam int CNT_W = $clog2(RX_TIMEOUT + 1);

  // ---------------------------------------------------------------- RX path
  rx_state_t          rx_next;
  logic [BYTE_W-1:0]  lo_byte;
  logic [CNT_W-1:0]   rx_cnt;
  logic               rx_expire;

  assign rx_expire = (rx_cnt == CNT_W'(RX_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_LO;
    else     rx_state <= rx_next;
  end

  // A byte arriving in the expiry cycle still completes the sample.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_LO:   if (rx_ready) rx_next = RX_HI;
      RX_HI:   if (rx_ready || rx_expire) rx_next = RX_LO;
      default: rx_next = RX_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_byte      <= '0;
      rx_cnt       <= '0;
      fir_in       <= '0;
      fir_in_valid <= 1'b0;
    end else begin
      fir_in_valid <= 1'b0;
      case (rx_state)
        RX_LO: begin
          if (rx_ready) begin
            lo_byte <= rx_data;
            rx_cnt  <= '0;
          end
        end
        RX_HI: begin
          if (rx_ready) begin
            fir_in       <= {rx_data, lo_byte};
            fir_in_valid <= 1'b1;
          end else if (rx_expire) begin
            lo_byte <= '0;
            rx_cnt  <= '0;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sample_led = fir_in;

  // ---------------------------------------------------------------- FIFO
  logic [DIN_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             unused_fir_bits;

  // Only the transmitted slice is stored; remaining result bits are dropped.
  assign unused_fir_bits = ^fir_out;

  sample_fifo #(
    .W     (DIN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fir_out_valid),
    .din   (fir_out[OUT_LSB +: DIN_W]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (fir_out_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t          tx_next;
  logic [BYTE_W-1:0]  hi_byte;
  logic               busy_seen;   // tx_busy observed high during *_WAIT

  assign fifo_pop = (tx_state == TX_IDLE) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next  = tx_state;
    tx_start = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!fifo_empty) tx_next = LO_START;
      LO_START: if (!tx_busy) begin tx_start = 1'b1; tx_next = LO_WAIT; end
      LO_WAIT:  if (busy_seen && !tx_busy) tx_next = HI_START;
      HI_START: if (!tx_busy) begin tx_start = 1'b1; tx_next = HI_WAIT; end
      HI_WAIT:  if (busy_seen && !tx_busy) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // tx_data is loaded on entry to each *_START state so it is already stable
  // in the request cycle and stays put until the byte completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data   <= '0;
      hi_byte   <= '0;
      busy_seen <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            tx_data   <= fifo_dout[BYTE_W-1:0];
            hi_byte   <= fifo_dout[DIN_W-1:BYTE_W];
            busy_seen <= 1'b0;
          end
        end
        LO_WAIT, HI_WAIT: begin
          if (!busy_seen) begin
            if (tx_busy) busy_seen <= 1'b1;
          end else if (!tx_busy) begin
            busy_seen <= 1'b0;
            if (tx_state == LO_WAIT) tx_data <= hi_byte;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_uart_sched.sv
module tb_fir_uart_sched;
  import fir_uart_pkg::*;

  localparam int RX_TO = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        fir_in_valid;
  logic [15:0] fir_in;
  logic        fir_out_valid;
  logic [37:0] fir_out;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [15:0] sample_led;
  logic        overflow;
  logic [2:0]  fifo_level;
  rx_state_t   rx_state;
  tx_state_t   tx_state;

  // transmitter model: model_busy follows tx_start, hold_busy forces busy
  logic model_busy;
  logic hold_busy;
  logic auto_en;
  assign tx_busy = model_busy | hold_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tx_lat_cyc = -1;
  logic prev_start = 1'b0;

  logic [15:0] exp_fir_q[$];
  int          exp_fir_cyc_q[$];
  logic [7:0]  exp_tx_q[$];

  logic [15:0] fir_exp_v;
  int          fir_exp_c;
  logic [7:0]  tx_exp_v;

  fir_uart_sched #(
    .DIN_W      (16),
    .FIR_OUT_W  (38),
    .OUT_LSB    (8),
    .FIFO_DEPTH (4),
    .RX_TIMEOUT (RX_TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .fir_in_valid  (fir_in_valid),
    .fir_in        (fir_in),
    .fir_out_valid (fir_out_valid),
    .fir_out       (fir_out),
    .tx_busy       (tx_busy),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .sample_led    (sample_led),
    .overflow      (overflow),
    .fifo_level    (fifo_level),
    .rx_state      (rx_state),
    .tx_state      (tx_state)
  );

  // ------------------------------------------------ clock / reset block
  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------ helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------ driver tasks
  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b1;
    rx_data  = b;
    step();
    rx_ready = 1'b0;
  endtask

  // The high byte was just sampled; the strobe is due in the current cycle.
  task automatic send_sample(input logic [7:0] lo, input logic [7:0] hi, input int gap);
    send_byte(lo);
    repeat (gap) step();
    send_byte(hi);
    exp_fir_q.push_back({hi, lo});
    exp_fir_cyc_q.push_back(cyc);
  endtask

  function automatic logic [37:0] make_result(input logic [15:0] w);
    return {14'h2AAA, w, 8'h5A};
  endfunction

  task automatic expect_word(input logic [15:0] w);
    exp_tx_q.push_back(w[7:0]);
    exp_tx_q.push_back(w[15:8]);
  endtask

  task automatic push_result(input logic [37:0] v);
    fir_out_valid = 1'b1;
    fir_out       = v;
    step();
    fir_out_valid = 1'b0;
  endtask

  task automatic busy_pulse();
    repeat (2) step();
    hold_busy = 1'b1;
    repeat (3) step();
    hold_busy = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_tx_q.size() != 0 || fifo_level != 0 || tx_state != TX_IDLE || tx_busy) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(n >= budget), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_fir_q.delete();
    exp_fir_cyc_q.delete();
    exp_tx_q.delete();
    tx_lat_cyc = -1;
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_fir_in_valid", fir_in_valid, 0);
    check("rst_fir_in", fir_in, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_sample_led", sample_led, 0);
    check("rst_overflow", overflow, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_rx_state", rx_state, RX_LO);
    check("rst_tx_state", tx_state, TX_IDLE);
    step();
  endtask

  // ------------------------------------------------ scoreboard monitors
  initial forever begin
    @(negedge clk);
    if (fir_in_valid) begin
      if (exp_fir_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fir_unexpected: actual=%0h required=no_strobe", fir_in);
      end else begin
        fir_exp_v = exp_fir_q.pop_front();
        fir_exp_c = exp_fir_cyc_q.pop_front();
        check("fir_in", fir_in, fir_exp_v);
        check("sample_led", sample_led, fir_exp_v);
        check("fir_latency", 64'(cyc), 64'(fir_exp_c));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      check("tx_start_while_busy", tx_busy, 0);
      check("tx_start_back_to_back", prev_start, 0);
      if (exp_tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: actual=%0h required=no_start", tx_data);
      end else begin
        tx_exp_v = exp_tx_q.pop_front();
        check("tx_data", tx_data, tx_exp_v);
      end
      if (tx_lat_cyc >= 0) begin
        check("tx_latency", 64'(cyc), 64'(tx_lat_cyc));
        tx_lat_cyc = -1;
      end
    end
    prev_start = tx_start;
  end

  // transmitter: busy one cycle after a start, for 100 cycles
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && auto_en) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (100) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  // ------------------------------------------------ stimulus
  initial begin
    logic [15:0] words[6];
    int n;
    words = '{16'hA101, 16'hB202, 16'hC303, 16'hD404, 16'hE505, 16'hF606};
    rst = 1'b1; rx_ready = 1'b0; rx_data = '0;
    fir_out_valid = 1'b0; fir_out = '0;
    hold_busy = 1'b0; auto_en = 1'b1;
    step();
    do_reset();
    check_reset_outputs();

    // pairing: 0x34 then 0x12
    send_sample(8'h34, 8'h12, 9);
    repeat (5) step();
    @(negedge clk);
    check("s1_sample_led_hold", sample_led, 16'h1234);
    step();

    // timeout: 0xAA is discarded, 0x01/0x02 form the next sample
    send_byte(8'hAA);
    repeat (RX_TO) step();
    @(negedge clk);
    check("s2_rx_state_after_timeout", rx_state, RX_LO);
    step();
    send_sample(8'h01, 8'h02, 2);
    repeat (5) step();

    // single result: bytes 0x34 then 0x12, first start two cycles after strobe
    expect_word(16'h1234);
    push_result(38'h00_0012_3456);
    tx_lat_cyc = cyc + 1;
    wait_drain(600);

    // overflow: word 0 leaves for the hold register at once, words 1..4
    // fill the FIFO, word 5 is dropped
    hold_busy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) expect_word(words[k]);
      fir_out_valid = 1'b1;
      fir_out = make_result(words[k]);
      step();
    end
    fir_out_valid = 1'b0;
    @(negedge clk);
    check("s4_fifo_level_full", fifo_level, 4);
    check("s4_overflow_set", overflow, 1);
    step();
    hold_busy = 1'b0;
    wait_drain(3000);
    check("s4_overflow_sticky", overflow, 1);

    do_reset();
    check_reset_outputs();

    // full FIFO with simultaneous pop and push
    auto_en = 1'b0;
    hold_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_word(words[k]);
      fir_out_valid = 1'b1;
      fir_out = make_result(words[k]);
      step();
    end
    fir_out_valid = 1'b0;
    @(negedge clk);
    check("s5_fifo_level_full", fifo_level, 4);
    step();
    hold_busy = 1'b0;
    busy_pulse();
    busy_pulse();
    n = 0;
    @(negedge clk);
    while (tx_state != TX_IDLE && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("s5_idle_timeout", 64'(n >= 50), 64'(0));
    expect_word(words[5]);
    fir_out_valid = 1'b1;
    fir_out = make_result(words[5]);
    step();
    fir_out_valid = 1'b0;
    @(negedge clk);
    check("s5_fifo_level_kept", fifo_level, 4);
    check("s5_overflow_clear", overflow, 0);
    step();
    auto_en = 1'b1;
    hold_busy = 1'b1;
    step();
    hold_busy = 1'b0;
    wait_drain(3000);

    // reset during HI_WAIT with a word queued and a low byte pending
    expect_word(16'h5678);
    push_result(make_result(16'h5678));
    push_result(make_result(16'h9ABC));
    n = 0;
    while (tx_state != HI_WAIT && n < 600) begin
      step();
      n++;
    end
    check("s6_hi_wait_timeout", 64'(n >= 600), 64'(0));
    send_byte(8'h77);
    do_reset();
    check_reset_outputs();
    send_sample(8'h34, 8'h12, 9);
    repeat (5) step();
    expect_word(16'h1234);
    push_result(38'h00_0012_3456);
    wait_drain(800);

    repeat (5) step();
    check("end_fir_queue_empty", 64'(exp_fir_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
